as_arbiter: RTL and testbench

AS_ARBITER -- requirements
Module: as_arbiter

---
 rtl/as_arbiter_if.sv | 26 ++
 rtl/as_arbiter.sv | 79 +++++++
 tb/tb_as_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/as_arbiter_if.sv
// Request/response bundle shared by the two requesters, the consumer and as_arbiter.
// The arbiter uses the slave modport; the requester/consumer side uses the master modport.
interface as_arbiter_if #(parameter int WIDTH = 32);
  logic             r0_valid, r0_mode, r0_ready;
  logic [WIDTH-1:0] r0_op1, r0_op2;
  logic             r1_valid, r1_mode, r1_ready;
  logic [WIDTH-1:0] r1_op1, r1_op2;
  logic             rsp_valid, rsp_id, rsp_flag, rsp_ready;
  logic [WIDTH-1:0] rsp_result;

  modport slave (
    input  r0_valid, r0_mode, r0_op1, r0_op2,
    input  r1_valid, r1_mode, r1_op1, r1_op2,
    input  rsp_ready,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flag
  );

  modport master (
    output r0_valid, r0_mode, r0_op1, r0_op2,
    output r1_valid, r1_mode, r1_op1, r1_op2,
    output rsp_ready,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flag
  );
endinterface

// File: rtl/as_arbiter.sv
// Two-requester round-robin arbiter feeding a single add/sub unit with a one-entry
// response register; a new request can load on the same edge the old response retires.
module as_arbiter #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  as_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  typedef enum logic {IDLE, RESP} state_e;

  state_e state_q, state_d;
  logic   prio_q;

  logic [NUM_REQ-1:0]            vld, mode, rdy;
  logic [NUM_REQ-1:0][WIDTH-1:0] op1, op2;

  logic             win_open, gnt_vld, gnt_id, acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_q;
  logic             flag_q, id_q;

  assign vld  = {bus.r1_valid, bus.r0_valid};
  assign mode = {bus.r1_mode,  bus.r0_mode};
  assign op1  = {bus.r1_op1,   bus.r0_op1};
  assign op2  = {bus.r1_op2,   bus.r0_op2};

  always_comb begin
    win_open = 1'b0;
    gnt_vld  = 1'b0;
    gnt_id   = 1'b0;
    acc      = 1'b0;
    rdy      = '0;
    state_d  = state_q;
    win_open = (state_q == IDLE) || bus.rsp_ready;
    gnt_vld  = |vld;
    // Contention is settled by prio; otherwise the lone valid wins.
    gnt_id   = (&vld) ? prio_q : vld[1];
    // Nothing is accepted on an edge where reset is asserted.
    acc      = rst && win_open && gnt_vld;
    if (acc) begin
      rdy[gnt_id] = 1'b1;
      state_d     = RESP;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end

  // Borrow for subtract falls out of bit WIDTH of the zero-extended difference.
  assign sum = mode[gnt_id] ? ({1'b0, op1[gnt_id]} - {1'b0, op2[gnt_id]})
                            : ({1'b0, op1[gnt_id]} + {1'b0, op2[gnt_id]});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        prio_q <= ~gnt_id;
        res_q  <= sum[WIDTH-1:0];
        flag_q <= sum[WIDTH];
        id_q   <= gnt_id;
      end
    end
  end

  assign bus.r0_ready   = rdy[0];
  assign bus.r1_ready   = rdy[1];
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flag   = flag_q;
endmodule

// File: tb/tb_as_arbiter.sv
// Directed bench for as_arbiter: single ops, wrap/borrow, contention, backpressure,
// reset mid-operation and drain to idle, with hand-computed expectations.
module tb_as_arbiter;
  localparam int WIDTH = 32;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  as_arbiter_if #(.WIDTH(WIDTH)) bus ();

  as_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen after a further 1 unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int id, input logic v, input logic m,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (id == 0) begin
      bus.r0_valid = v; bus.r0_mode = m; bus.r0_op1 = a; bus.r0_op2 = b;
    end else begin
      bus.r1_valid = v; bus.r1_mode = m; bus.r1_op1 = a; bus.r1_op2 = b;
    end
  endtask

  task automatic chk_rdy(input string tag, input logic e0, input logic e1);
    #1;
    chk({tag, "_r0_ready"}, 64'(bus.r0_ready), 64'(e0));
    chk({tag, "_r1_ready"}, 64'(bus.r1_ready), 64'(e1));
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [WIDTH-1:0] res, input logic fl);
    chk({tag, "_valid"},  64'(bus.rsp_valid),  64'(v));
    chk({tag, "_id"},     64'(bus.rsp_id),     64'(id));
    chk({tag, "_result"}, 64'(bus.rsp_result), 64'(res));
    chk({tag, "_flag"},   64'(bus.rsp_flag),   64'(fl));
  endtask

  initial begin
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    req(0, 1'b1, 1'b0, 32'd5, 32'd7);
    req(1, 1'b0, 1'b0, '0, '0);

    // Reset: a valid request must not be accepted while rst = 0.
    step(); step();
    chk_rdy("rst", 1'b0, 1'b0);
    chk_rsp("rst", 1'b0, 1'b0, '0, 1'b0);
    req(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step();

    // Single add 5 + 7.
    req(0, 1'b1, 1'b0, 32'd5, 32'd7);
    chk_rdy("add", 1'b1, 1'b0);
    step();
    req(0, 1'b0, 1'b0, '0, '0);
    chk_rsp("add", 1'b1, 1'b0, 32'd12, 1'b0);

    // Drain: no requests, response retires, payload retained.
    #1; step();
    chk_rsp("drain", 1'b0, 1'b0, 32'd12, 1'b0);

    // r1 subtract 3 - 5 borrows.
    req(1, 1'b1, 1'b1, 32'd3, 32'd5);
    chk_rdy("sub", 1'b0, 1'b1);
    step();
    req(1, 1'b0, 1'b0, '0, '0);
    chk_rsp("sub", 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);

    // Back-to-back from RESP: add wraps with carry.
    req(0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk_rdy("wrap", 1'b1, 1'b0);
    step();
    req(0, 1'b0, 1'b0, '0, '0);
    chk_rsp("wrap", 1'b1, 1'b0, 32'd0, 1'b1);
    #1; step();

    // Contention straight after reset: grants alternate starting with 0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    req(0, 1'b1, 1'b0, 32'd10, 32'd1);
    req(1, 1'b1, 1'b1, 32'd20, 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = logic'(i % 2);
      chk_rdy($sformatf("cont%0d", i), ~g, g);
      step();
      chk_rsp($sformatf("cont%0d", i), 1'b1, g, g ? 32'd16 : 32'd11, 1'b0);
    end

    // Backpressure: held response is stable and nothing is accepted.
    req(0, 1'b0, 1'b0, '0, '0);
    req(1, 1'b1, 1'b0, 32'd100, 32'd200);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      step();
      chk_rsp($sformatf("bp%0d", i), 1'b1, 1'b1, 32'd16, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    chk_rdy("bp_rel", 1'b0, 1'b1);
    step();
    req(1, 1'b0, 1'b0, '0, '0);
    chk_rsp("bp_rel", 1'b1, 1'b1, 32'd300, 1'b0);

    // Reset mid-operation after an r0 grant (prio would otherwise favour r1).
    req(0, 1'b1, 1'b0, 32'd5, 32'd7);
    step();
    req(0, 1'b0, 1'b0, '0, '0);
    chk_rsp("pre_rst", 1'b1, 1'b0, 32'd12, 1'b0);
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    step();
    chk_rsp("mid_rst", 1'b0, 1'b0, 32'd0, 1'b0);
    req(0, 1'b1, 1'b0, 32'd2, 32'd3);
    req(1, 1'b1, 1'b0, 32'd4, 32'd5);
    chk_rdy("in_rst", 1'b0, 1'b0);
    rst = 1'b1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    step();
    req(0, 1'b0, 1'b0, '0, '0);
    req(1, 1'b0, 1'b0, '0, '0);
    chk_rsp("post_rst", 1'b1, 1'b0, 32'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
